// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and issue-side handshake bundle for decode_stage
interface decode_stage_if #(
  parameter int XLEN    = 32,
  parameter int IADDR_W = 20
);
  logic               in_valid;
  logic [31:0]        instruction;
  logic [XLEN-1:0]    pc;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [6:0]         opcode;
  logic [4:0]         rd;
  logic [2:0]         f3;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic               f7;
  logic [XLEN-1:0]    imm;
  logic [2:0]         itype;
  logic [IADDR_W-1:0] address;
  logic               illegal;

  modport master (
    output in_valid, instruction, pc, out_ready,
    input  in_ready, out_valid, opcode, rd, f3, rs1, rs2, f7, imm, itype, address, illegal
  );

  modport slave (
    input  in_valid, instruction, pc, out_ready,
    output in_ready, out_valid, opcode, rd, f3, rs1, rs2, f7, imm, itype, address, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-entry RV32I decode register stage with valid/ready flow
// Defining DECODE_ILLEGAL_CHECK_EN adds a registered illegal-instruction flag.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int IADDR_W = 20,
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [XLEN-1:0]    alu_o,
  output logic [DADDR_W-1:0] addr,
  decode_stage_if.slave      bus
);
  localparam logic [2:0] IT_R = 3'd0, IT_I = 3'd1, IT_S = 3'd2, IT_B = 3'd3,
                         IT_U = 3'd4, IT_J = 3'd5, IT_X = 3'd7;

  logic [31:0]        w_ins;
  logic               w_in_ready;
  logic               w_accept;
  logic [2:0]         w_itype;
  logic [XLEN-1:0]    w_imm;
  logic               w_unused_bits;

  logic               r_out_valid;
  logic [6:0]         r_opcode;
  logic [4:0]         r_rd;
  logic [2:0]         r_f3;
  logic [4:0]         r_rs1;
  logic [4:0]         r_rs2;
  logic               r_f7;
  logic [XLEN-1:0]    r_imm;
  logic [2:0]         r_itype;
  logic [IADDR_W-1:0] r_address;

  assign w_ins      = bus.instruction;
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Address path is a pure slice of the ALU result, independent of the pipeline register.
  assign addr = alu_o[DADDR_W+1:2];

  assign w_unused_bits = ^{bus.pc[1:0], bus.pc[XLEN-1:IADDR_W+2], alu_o[1:0], alu_o[XLEN-1:DADDR_W+2]};

  always_comb begin
    w_itype = IT_X;
    case (w_ins[6:0])
      7'h33:                             w_itype = IT_R;
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: w_itype = IT_I;
      7'h23:                             w_itype = IT_S;
      7'h63:                             w_itype = IT_B;
      7'h37, 7'h17:                      w_itype = IT_U;
      7'h6F:                             w_itype = IT_J;
      default:                           w_itype = IT_X;
    endcase
  end

  // Signed casts do the sign extension from instr[31] up to XLEN.
  always_comb begin
    w_imm = '0;
    case (w_itype)
      IT_I:    w_imm = XLEN'($signed(w_ins[31:20]));
      IT_S:    w_imm = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
      IT_B:    w_imm = XLEN'($signed({w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0}));
      IT_U:    w_imm = XLEN'($signed({w_ins[31:12], 12'b0}));
      IT_J:    w_imm = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}));
      default: w_imm = '0;
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic       w_illegal;
  logic       r_illegal;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_f3 = w_ins[14:12];
  assign w_f7 = w_ins[31:25];

  always_comb begin
    w_illegal = 1'b0;
    case (w_ins[6:0])
      7'h37, 7'h17, 7'h6F: w_illegal = 1'b0;
      7'h67: w_illegal = (w_f3 != 3'd0);
      7'h63: w_illegal = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      7'h03: w_illegal = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      7'h23: w_illegal = (w_f3 > 3'd2);
      7'h13: w_illegal = ((w_f3 == 3'd1) && (w_f7 != 7'h00)) ||
                         ((w_f3 == 3'd5) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
      7'h33: w_illegal = !((w_f7 == 7'h00) ||
                           ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
      7'h0F: w_illegal = (w_f3 > 3'd1);
      7'h73: w_illegal = (w_f3 == 3'd4);
      default: w_illegal = 1'b1;
    endcase
  end

  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  // Flush wins over a same-cycle accept; the offered word is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_rd        <= '0;
      r_f3        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_f7        <= 1'b0;
      r_imm       <= '0;
      r_itype     <= IT_X;
      r_address   <= '0;
`ifdef DECODE_ILLEGAL_CHECK_EN
      r_illegal   <= 1'b0;
`endif
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_opcode    <= w_ins[6:0];
      r_rd        <= w_ins[11:7];
      r_f3        <= w_ins[14:12];
      r_rs1       <= w_ins[19:15];
      r_rs2       <= w_ins[24:20];
      r_f7        <= w_ins[30];
      r_imm       <= w_imm;
      r_itype     <= w_itype;
      r_address   <= bus.pc[IADDR_W+1:2];
`ifdef DECODE_ILLEGAL_CHECK_EN
      r_illegal   <= w_illegal;
`endif
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.opcode    = r_opcode;
  assign bus.rd        = r_rd;
  assign bus.f3        = r_f3;
  assign bus.rs1       = r_rs1;
  assign bus.rs2       = r_rs2;
  assign bus.f7        = r_f7;
  assign bus.imm       = r_imm;
  assign bus.itype     = r_itype;
  assign bus.address   = r_address;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a queue-based reference model
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] alu_o;
  logic [7:0]  addr;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct { logic [31:0] ins; logic [31:0] pc; } word_t;

  decode_stage_if #(.XLEN(32), .IADDR_W(20)) bus();

  decode_stage #(.XLEN(32), .IADDR_W(20), .DADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .alu_o (alu_o),
    .addr  (addr),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [81:0] w_obs;
  assign w_obs = {bus.opcode, bus.rd, bus.f3, bus.rs1, bus.rs2, bus.f7,
                  bus.imm, bus.itype, bus.address, bus.illegal};

  localparam logic [81:0] RESET_FIELDS = {7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 1'b0,
                                          32'd0, 3'd7, 20'd0, 1'b0};

  function automatic logic model_illegal(input logic [31:0] ins);
`ifdef DECODE_ILLEGAL_CHECK_EN
    int f3 = int'(ins[14:12]);
    int f7 = int'(ins[31:25]);
    if (ins[1:0] != 2'b11) return 1'b1;
    case (ins[6:0])
      7'h37, 7'h17, 7'h6F: return 1'b0;
      7'h67: return f3 != 0;
      7'h63: return f3 == 2 || f3 == 3;
      7'h03: return f3 == 3 || f3 >= 6;
      7'h23: return f3 > 2;
      7'h13: return (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 32));
      7'h33: return !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      7'h0F: return f3 > 1;
      7'h73: return f3 == 4;
      default: return 1'b1;
    endcase
`else
    return ins[0] & 1'b0;
`endif
  endfunction

  // Immediates built as unsigned field values, then two's-complement corrected by subtraction.
  function automatic logic [81:0] model(input logic [31:0] ins, input logic [31:0] pc);
    logic [2:0] it;
    longint     v;
    case (ins[6:0])
      7'h33: it = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: it = 3'd1;
      7'h23: it = 3'd2;
      7'h63: it = 3'd3;
      7'h37, 7'h17: it = 3'd4;
      7'h6F: it = 3'd5;
      default: it = 3'd7;
    endcase
    v = 0;
    case (it)
      3'd1: begin v = longint'(ins[31:20]); if (ins[31]) v -= 4096; end
      3'd2: begin v = longint'({ins[31:25], ins[11:7]}); if (ins[31]) v -= 4096; end
      3'd3: begin v = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); if (ins[31]) v -= 8192; end
      3'd4: v = longint'(ins[31:12]) * 4096;
      3'd5: begin v = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); if (ins[31]) v -= 2097152; end
      default: v = 0;
    endcase
    return {ins[6:0], ins[11:7], ins[14:12], ins[19:15], ins[24:20], ins[30],
            v[31:0], it, pc[21:2], model_illegal(ins)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid    = 1'b0;
    bus.instruction = 32'h0;
    bus.pc          = 32'h0;
    bus.out_ready   = 1'b1;
    flush           = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    alu_o = 32'h0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++;
    if (w_obs !== RESET_FIELDS) begin n_fail++; $display("FAIL reset_fields got %h want %h", w_obs, RESET_FIELDS); end
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_addi;
    bus.in_valid = 1'b1; bus.instruction = 32'h00A30293; bus.pc = 32'h100; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b want 1", bus.out_valid); end
    n_checks++;
    if ({bus.rd, bus.rs1, bus.f3, bus.itype} !== {5'd5, 5'd6, 3'd0, 3'd1}) begin
      n_fail++; $display("FAIL addi_regs got rd=%0d rs1=%0d f3=%0d itype=%0d want 5 6 0 1", bus.rd, bus.rs1, bus.f3, bus.itype);
    end
    n_checks++;
    if (bus.imm !== 32'd10) begin n_fail++; $display("FAIL addi_imm got %h want 0000000a", bus.imm); end
    n_checks++;
    if (bus.address !== 20'h40) begin n_fail++; $display("FAIL addi_address got %h want 40", bus.address); end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_jal;
    bus.in_valid = 1'b1; bus.instruction = 32'hFE5FF0EF; bus.pc = 32'h2000; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.itype, bus.rd} !== {1'b1, 3'd5, 5'd1}) begin
      n_fail++; $display("FAIL jal_fields got v=%b itype=%0d rd=%0d want 1 5 1", bus.out_valid, bus.itype, bus.rd);
    end
    n_checks++;
    if (bus.imm !== 32'hFFFFFFE4) begin n_fail++; $display("FAIL jal_imm got %h want ffffffe4", bus.imm); end
    tick();
  endtask

  task automatic test_stall;
    logic [81:0] exp_a, exp_b;
    exp_a = model(32'h40B50533, 32'h300);
    exp_b = model(32'h00112623, 32'h304);
    bus.in_valid = 1'b1; bus.instruction = 32'h40B50533; bus.pc = 32'h300; bus.out_ready = 1'b0;
    tick();
    bus.instruction = 32'h00112623; bus.pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cycle %0d got %b want 0", i, bus.in_ready); end
      n_checks++;
      if ({bus.out_valid, w_obs} !== {1'b1, exp_a}) begin
        n_fail++; $display("FAIL stall_hold cycle %0d got %b/%h want 1/%h", i, bus.out_valid, w_obs, exp_a);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, w_obs} !== {1'b1, exp_b}) begin
      n_fail++; $display("FAIL stall_next_word got %b/%h want 1/%h", bus.out_valid, w_obs, exp_b);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_duplicate got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush;
    bus.in_valid = 1'b1; bus.instruction = 32'h00A30293; bus.pc = 32'h400; bus.out_ready = 1'b0;
    tick();
    bus.instruction = 32'hFE5FF0EF; bus.out_ready = 1'b1; flush = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear got %b want 0", bus.out_valid); end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stays_clear got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_stall;
    bus.in_valid = 1'b1; bus.instruction = 32'h00A30293; bus.pc = 32'h500; bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.itype} !== {1'b0, 3'd7}) begin
      n_fail++; $display("FAIL reset_stall got v=%b itype=%0d want 0 7", bus.out_valid, bus.itype);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_stall_ready got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_illegal_addr;
    logic exp_ill;
`ifdef DECODE_ILLEGAL_CHECK_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    bus.in_valid = 1'b1; bus.instruction = 32'h0; bus.pc = 32'h600; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.illegal, bus.itype, bus.imm} !== {exp_ill, 3'd7, 32'd0}) begin
      n_fail++; $display("FAIL zero_word got ill=%b itype=%0d imm=%h want %b 7 0", bus.illegal, bus.itype, bus.imm, exp_ill);
    end
    alu_o = 32'h3FC; reset = 1'b1;
    #1;
    n_checks++;
    if (addr !== 8'hFF) begin n_fail++; $display("FAIL addr_slice got %h want ff", addr); end
    tick();
    reset = 1'b0;
    alu_o = 32'h12345678;
    #1;
    n_checks++;
    if (addr !== 8'h9E) begin n_fail++; $display("FAIL addr_slice2 got %h want 9e", addr); end
    tick();
  endtask

  // Random traffic: a one-deep queue stands in for the stage; delivery pops, acceptance pushes.
  task automatic test_random_stream;
    word_t       q[$];
    word_t       w;
    logic [6:0]  ops[11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [31:0] r;
    logic [6:0]  op;
    logic [81:0] exp;
    logic        exp_rdy;
    int          n_in = 0, n_out = 0;
    int          k;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++;
      if (bus.out_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid cycle %0d got %b want %b", cyc, bus.out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        exp = model(q[0].ins, q[0].pc);
        n_checks++;
        if (w_obs !== exp) begin n_fail++; $display("FAIL rand_fields cycle %0d got %h want %h", cyc, w_obs, exp); end
      end
      r  = $urandom();
      k  = $urandom_range(0, 12);
      op = (k < 11) ? ops[k] : r[6:0];
      bus.in_valid    = (cyc < 380) && ($urandom_range(0, 3) != 0);
      bus.out_ready   = ($urandom_range(0, 2) != 0);
      bus.instruction = {r[31:7], op};
      bus.pc          = $urandom();
      #1;
      exp_rdy = (q.size() == 0) || bus.out_ready;
      n_checks++;
      if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready cycle %0d got %b want %b", cyc, bus.in_ready, exp_rdy); end
      if (q.size() != 0 && bus.out_ready) begin void'(q.pop_front()); n_out++; end
      if (bus.in_valid && exp_rdy) begin
        w.ins = bus.instruction; w.pc = bus.pc; q.push_back(w); n_in++;
      end
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    if (q.size() != 0) begin void'(q.pop_front()); n_out++; end
    tick();
    n_checks++;
    if ({bus.out_valid, n_out} !== {1'b0, n_in}) begin
      n_fail++; $display("FAIL rand_conservation got v=%b delivered=%0d want 0 accepted=%0d", bus.out_valid, n_out, n_in);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    alu_o = 32'h0;
    test_reset();
    test_addi();
    test_jal();
    test_stall();
    test_flush();
    test_reset_stall();
    test_illegal_addr();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and PC width (32 or 64).
REQ-002 SHALL have parameter IADDR_W, default 20, meaning instruction word-address width taken from pc[IADDR_W+1:2].
REQ-003 SHALL have parameter DADDR_W, default 8, meaning data word-address width taken from alu_o[DADDR_W+1:2].
REQ-004 SHALL have ports: clk input 1, sole clock, rising edge; reset input 1, synchronous, active-high.
REQ-005 SHALL have ports: in_valid input 1, instruction offered; instruction input 32, raw RV32I word; pc input XLEN, fetch PC; in_ready output 1, stage accepts.
REQ-006 SHALL have ports: alu_o input XLEN, ALU result (combinational path, not registered); addr output DADDR_W, alu_o[DADDR_W+1:2].
REQ-007 SHALL have ports: flush input 1, discard held instruction.
REQ-008 SHALL have ports: out_valid output 1; out_ready input 1; opcode output 7; rd output 5; f3 output 3; rs1 output 5; rs2 output 5; f7 output 1 (instr[30]); imm output XLEN, sign-extended immediate; itype output 3, format code; address output IADDR_W; illegal output 1.

Function
REQ-009 SHALL register decoded fields: a word accepted on clk edge where in_valid && in_ready appears on outputs the next cycle with out_valid=1 (latency 1).
REQ-010 SHALL drive in_ready = !out_valid || out_ready (combinational, no bubble under continuous flow).
REQ-011 SHALL hold all registered outputs stable while out_valid && !out_ready.
REQ-012 SHALL clear out_valid when out_valid && out_ready && !(in_valid && in_ready).
REQ-013 SHALL extract opcode=instr[6:0], rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20], f7=[30], address=pc[IADDR_W+1:2].
REQ-014 SHALL encode itype as R=0, I=1, S=2, B=3, U=4, J=5, other=7, by opcode.
REQ-015 SHALL build imm per format, sign bit instr[31] extended to XLEN: I {[31:20]}, S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0}, U {[31:12],12'b0}, J {[31],[19:12],[20],[30:21],0}; R and other give imm=0.
REQ-016 SHALL on flush clear out_valid next cycle; flush beats a simultaneous accept (new word discarded); in_ready unaffected by flush.
REQ-017 SHALL on reset asserted mid-transaction drop any held word; in_ready=1 in the cycle after reset deasserts.

Reset
REQ-018 SHALL reset out_valid=0, illegal=0, imm=0, itype=7 and opcode, rd, f3, rs1, rs2, f7, address to 0.
REQ-019 SHALL keep addr purely combinational from alu_o, unaffected by reset.

Configuration
REQ-020 SHALL, with DECODE_ILLEGAL_CHECK_EN defined, set registered illegal=1 when instr[1:0]!=2'b11, opcode is not an RV32I base opcode, or f3/f7 combination is undefined for that opcode; fields still decoded.
REQ-021 SHALL, without DECODE_ILLEGAL_CHECK_EN, tie illegal to 0 with no check logic.

Verification
REQ-022 SHALL cover: accept 0x00A30293 (addi x5,x6,10), pc=0x100 -> next cycle out_valid=1, rd=5, rs1=6, f3=0, itype=1, imm=10, address=0x40.
REQ-023 SHALL cover: 0xFE5FF0EF (jal x1,-28) -> itype=5, rd=1, imm=0xFFFFFFE4.
REQ-024 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next word appears following cycle, none lost or duplicated.
REQ-025 SHALL cover: flush and accept same cycle -> out_valid=0 next cycle; reset during stall -> out_valid=0, itype=7.
REQ-026 SHALL cover: with DECODE_ILLEGAL_CHECK_EN, 0x00000000 -> illegal=1; without, illegal=0; alu_o=0x3FC -> addr=0xFF.
